// File: rtl/pulseox_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pulseox_pkg
//  Description : Shared encodings for the pulse-ox AFE readout path: mode
//                control codes, diagnostic result codes and default widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package pulseox_pkg;

    // in_data_control encodings; 2'b11 is reserved and behaves as idle
    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_DIAG = 2'b01;
    localparam logic [1:0] MODE_STRM = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    // out_diag_er result codes
    localparam logic [1:0] DIAG_PEND = 2'b00;
    localparam logic [1:0] DIAG_OK   = 2'b10;
    localparam logic [1:0] DIAG_ERR  = 2'b01;

    // Default datapath widths shared with the FIFO/ALU side
    localparam int DEF_DATA_W = 22;
    localparam int DEF_RAM_W  = 24;

    // Fold the reserved mode onto idle so downstream logic sees three modes
    function automatic logic [1:0] norm_mode(input logic [1:0] mode);
        return (mode == MODE_RSVD) ? MODE_IDLE : mode;
    endfunction

    // Diagnostic verdict: any set error bit means the AFE reported a fault
    function automatic logic [1:0] diag_classify(input logic all_zero);
        return all_zero ? DIAG_OK : DIAG_ERR;
    endfunction

endpackage
`default_nettype wire

// File: rtl/afe_rd_slot.sv
`default_nettype none
// ============================================================================
//  Module      : afe_rd_slot
//  Description : Read-latency slot counter. While enabled it counts cycles
//                since the address was presented and fires a one-cycle
//                capture strobe once RD_LAT+1 cycles have elapsed, then
//                restarts for the next address.
//  Revision    : 1.0 - initial release
// ============================================================================
module afe_rd_slot #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_fire
);

    localparam logic [2:0] c_lat = 3'(RD_LAT);

    logic [2:0] r_wait;

    // Data is valid on the cycle the counter reaches the configured latency
    assign o_fire = i_en && (r_wait == c_lat);

    // Count latency cycles, wrapping to zero on each capture
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wait <= 3'd0;
        end else if (i_en) begin
            r_wait <= o_fire ? 3'd0 : (r_wait + 3'd1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/afe_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : afe_frame_sequencer
//  Description : On each AFE data-ready strobe, reads NUM_CH result registers
//                through the AFE read-RAM port (honouring RD_LAT) into shadow
//                registers, then publishes them as one packed frame with a
//                single-cycle valid, wrapping frame counter and sticky
//                overrun flag. Also runs the one-shot diagnostic read.
//  Revision    : 1.0 - initial release
// ============================================================================
module afe_frame_sequencer
    import pulseox_pkg::*;
#(
    parameter int NUM_CH    = 6,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RAM_W     = DEF_RAM_W,
    parameter int ADDR_W    = 3,
    parameter int RD_LAT    = 1,
    parameter int DIAG_ADDR = 6,
    parameter int DIAG_W    = 14,
    parameter int CNT_W     = 8
) (
    input  logic                     clk,
    input  logic                     in_reset,
    input  logic [1:0]               in_data_control,
    input  logic                     in_strm_dn,
    input  logic [RAM_W-1:0]         in_strm_data,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [NUM_CH*DATA_W-1:0] out_samples,
    output logic                     out_sample_valid,
    output logic [CNT_W-1:0]         out_frame_cnt,
    output logic                     out_overrun,
    output logic                     out_busy,
    output logic [DIAG_W-1:0]        out_er_data,
    output logic [1:0]               out_diag_er
);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_read      = 3'd1;
    localparam logic [2:0] c_st_publish   = 3'd2;
    localparam logic [2:0] c_st_diag_rd   = 3'd3;
    localparam logic [2:0] c_st_diag_done = 3'd4;

    localparam logic [ADDR_W-1:0] c_last_ch   = ADDR_W'(NUM_CH - 1);
    localparam logic [ADDR_W-1:0] c_diag_addr = ADDR_W'(DIAG_ADDR);

    logic [2:0]               r_state;
    logic [ADDR_W-1:0]        r_ch;
    logic [ADDR_W-1:0]        r_addr;
    logic [NUM_CH*DATA_W-1:0] r_samples;
    logic                     r_valid;
    logic [CNT_W-1:0]         r_frame_cnt;
    logic                     r_overrun;
    logic [DIAG_W-1:0]        r_er_data;
    logic [1:0]               r_diag_er;

    logic [1:0]               w_mode;
    logic                     w_clear;
    logic                     w_slot_en;
    logic                     w_fire;
    logic                     w_cap;
    logic [NUM_CH*DATA_W-1:0] w_shadow;
    logic                     w_unused_data;

    // Reserved mode is idle; idle mode or reset wipes everything
    assign w_mode    = norm_mode(in_data_control);
    assign w_clear   = in_reset || (w_mode == MODE_IDLE);
    assign w_slot_en = (r_state == c_st_read) || (r_state == c_st_diag_rd);
    assign w_cap     = w_fire && (r_state == c_st_read) && (w_mode == MODE_STRM);

    // RAM bits above the captured width are don't-care for both paths
    assign w_unused_data = ^in_strm_data;

    // One latency counter shared by the frame read and the diagnostic read
    afe_rd_slot #(
        .RD_LAT (RD_LAT)
    ) u_rd_slot (
        .clk     (clk),
        .rst     (in_reset),
        .i_clear (w_clear || !w_slot_en),
        .i_en    (w_slot_en),
        .o_fire  (w_fire)
    );

    // Per-channel shadow registers, written only on that channel's capture
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        localparam logic [ADDR_W-1:0] c_idx = ADDR_W'(k);
        logic [DATA_W-1:0] r_sh;

        // Hold the captured sample until the frame is published or cleared
        always_ff @(posedge clk) begin
            if (w_clear) begin
                r_sh <= '0;
            end else if (w_cap && (r_ch == c_idx)) begin
                r_sh <= in_strm_data[DATA_W-1:0];
            end
        end

        assign w_shadow[k*DATA_W +: DATA_W] = r_sh;
    end

    // Main sequencer: frame read/publish, diagnostic read, overrun tracking
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state     <= c_st_idle;
            r_ch        <= '0;
            r_addr      <= '0;
            r_samples   <= '0;
            r_valid     <= 1'b0;
            r_frame_cnt <= '0;
            r_overrun   <= 1'b0;
            r_er_data   <= '0;
            r_diag_er   <= DIAG_PEND;
        end else begin
            r_valid <= 1'b0;

            // A strobe during an active frame is flagged and dropped
            if (in_strm_dn && ((r_state == c_st_read) || (r_state == c_st_publish))) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                c_st_idle: begin
                    if ((w_mode == MODE_STRM) && in_strm_dn) begin
                        r_state <= c_st_read;
                        r_ch    <= '0;
                        r_addr  <= '0;
                    end else if (w_mode == MODE_DIAG) begin
                        r_state   <= c_st_diag_rd;
                        r_addr    <= c_diag_addr;
                        r_diag_er <= DIAG_PEND;
                    end
                end

                c_st_read: begin
                    if (w_mode != MODE_STRM) begin
                        r_state <= c_st_idle;
                        r_addr  <= '0;
                    end else if (w_fire) begin
                        if (r_ch == c_last_ch) begin
                            r_state <= c_st_publish;
                        end else begin
                            r_ch   <= r_ch + ADDR_W'(1);
                            r_addr <= r_ch + ADDR_W'(1);
                        end
                    end
                end

                c_st_publish: begin
                    r_state <= c_st_idle;
                    r_addr  <= '0;
                    if (w_mode == MODE_STRM) begin
                        r_samples   <= w_shadow;
                        r_valid     <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                    end
                end

                c_st_diag_rd: begin
                    if (w_mode != MODE_DIAG) begin
                        r_state <= c_st_idle;
                        r_addr  <= '0;
                    end else if (w_fire) begin
                        r_er_data <= in_strm_data[DIAG_W-1:0];
                        r_state   <= c_st_diag_done;
                    end
                end

                c_st_diag_done: begin
                    if (w_mode != MODE_DIAG) begin
                        r_state <= c_st_idle;
                        r_addr  <= '0;
                    end else if (r_diag_er == DIAG_PEND) begin
                        r_diag_er <= diag_classify(r_er_data == '0);
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                    r_addr  <= '0;
                end
            endcase
        end
    end

    assign out_addr         = r_addr;
    assign out_samples      = r_samples;
    assign out_sample_valid = r_valid;
    assign out_frame_cnt    = r_frame_cnt;
    assign out_overrun      = r_overrun;
    assign out_busy         = (r_state == c_st_read) || (r_state == c_st_publish) ||
                              (r_state == c_st_diag_rd);
    assign out_er_data      = r_er_data;
    assign out_diag_er      = r_diag_er;

endmodule
`default_nettype wire

// File: tb/tb_afe_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_afe_frame_sequencer
//  Description : Self-checking bench: default instance plus a NUM_CH=4,
//                RD_LAT=3 instance, each fed by a latency-accurate RAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_afe_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        dn;
    logic [23:0] diag_reg;

    // default instance
    logic [23:0]  data1, p1;
    logic [2:0]   addr1;
    logic [131:0] sam1;
    logic         sv1, ovr1, busy1;
    logic [7:0]   cnt1;
    logic [13:0]  erd1;
    logic [1:0]   der1;

    // NUM_CH=4, RD_LAT=3 instance
    logic [23:0]  data2, q1, q2, q3;
    logic [2:0]   addr2;
    logic [87:0]  sam2;
    logic         sv2, ovr2, busy2;
    logic [7:0]   cnt2;
    logic [13:0]  erd2;
    logic [1:0]   der2;

    int n_cmp = 0;
    int n_err = 0;
    int nv1   = 0;
    int nv_mark;

    typedef struct {
        logic [23:0] ram;
        logic [1:0]  er;
        logic [13:0] data;
    } diag_vec_t;

    diag_vec_t   dv [6];
    logic [21:0] exp_ch [6];

    always #5 clk = ~clk;

    afe_frame_sequencer u_dut1 (
        .clk(clk), .in_reset(rst), .in_data_control(mode), .in_strm_dn(dn),
        .in_strm_data(data1), .out_addr(addr1), .out_samples(sam1),
        .out_sample_valid(sv1), .out_frame_cnt(cnt1), .out_overrun(ovr1),
        .out_busy(busy1), .out_er_data(erd1), .out_diag_er(der1)
    );

    afe_frame_sequencer #(.NUM_CH(4), .RD_LAT(3)) u_dut2 (
        .clk(clk), .in_reset(rst), .in_data_control(mode), .in_strm_dn(dn),
        .in_strm_data(data2), .out_addr(addr2), .out_samples(sam2),
        .out_sample_valid(sv2), .out_frame_cnt(cnt2), .out_overrun(ovr2),
        .out_busy(busy2), .out_er_data(erd2), .out_diag_er(der2)
    );

    // RAM contents: junk in bits above DATA_W, channel k = 0x100000+k
    function automatic logic [23:0] ram_rd(input logic [2:0] a);
        if (a == 3'd6) return diag_reg;
        return 24'hD00000 + {21'd0, a};
    endfunction

    // Read pipelines: RD_LAT register stages after the address
    always @(posedge clk) begin
        p1 <= ram_rd(addr1);
        q1 <= ram_rd(addr2);
        q2 <= q1;
        q3 <= q2;
    end
    assign data1 = p1;
    assign data2 = q3;

    always @(negedge clk) if (sv1 === 1'b1) nv1 = nv1 + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".addr"},    64'(addr1), 64'd0);
        chk({nm, ".samples"}, 64'(sam1 == '0), 64'd1);
        chk({nm, ".valid"},   64'(sv1), 64'd0);
        chk({nm, ".cnt"},     64'(cnt1), 64'd0);
        chk({nm, ".overrun"}, 64'(ovr1), 64'd0);
        chk({nm, ".busy"},    64'(busy1), 64'd0);
        chk({nm, ".er_data"}, 64'(erd1), 64'd0);
        chk({nm, ".diag_er"}, 64'(der1), 64'd0);
    endtask

    task automatic pulse();
        dn = 1'b1;
        @(negedge clk);
        dn = 1'b0;
    endtask

    task automatic chk_frame1(input string nm);
        for (int k = 0; k < 6; k++) chk(nm, 64'(sam1[k*22 +: 22]), 64'(exp_ch[k]));
    endtask

    initial begin
        dv[0] = '{24'h000000, 2'b10, 14'h0000};
        dv[1] = '{24'h000040, 2'b01, 14'h0040};
        dv[2] = '{24'hFFC000, 2'b10, 14'h0000};
        dv[3] = '{24'h002000, 2'b01, 14'h2000};
        dv[4] = '{24'h000001, 2'b01, 14'h0001};
        dv[5] = '{24'hABFFFF, 2'b01, 14'h3FFF};
        exp_ch = '{22'h100000, 22'h100001, 22'h100002, 22'h100003, 22'h100004, 22'h100005};

        rst = 1'b1; mode = 2'b00; dn = 1'b0; diag_reg = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0; mode = 2'b10;
        @(negedge clk);

        // single frame on both instances, cycle-by-cycle
        pulse();
        for (int j = 0; j <= 17; j++) begin
            chk("addr1", 64'(addr1), (j < 12) ? 64'(j / 2) : ((j == 12) ? 64'd5 : 64'd0));
            chk("addr2", 64'(addr2), (j < 16) ? 64'(j / 4) : ((j == 16) ? 64'd3 : 64'd0));
            chk("busy1", 64'(busy1), 64'(j <= 12));
            chk("busy2", 64'(busy2), 64'(j <= 16));
            chk("valid1", 64'(sv1), 64'(j == 13));
            chk("valid2", 64'(sv2), 64'(j == 17));
            if (j == 13) chk("cnt1", 64'(cnt1), 64'd1);
            if (j < 17) @(negedge clk);
        end
        chk_frame1("frame1.ch");
        for (int k = 0; k < 4; k++) chk("frame2.ch", 64'(sam2[k*22 +: 22]), 64'(exp_ch[k]));
        chk("cnt2", 64'(cnt2), 64'd1);
        chk("ovr1", 64'(ovr1), 64'd0);

        // second strobe at E0+5 -> sticky overrun, frame unaffected
        pulse();
        repeat (4) @(negedge clk);
        pulse();
        repeat (12) @(negedge clk);
        chk("ovr.flag", 64'(ovr1), 64'd1);
        chk("ovr.cnt", 64'(cnt1), 64'd2);
        chk_frame1("ovr.ch");
        repeat (5) @(negedge clk);
        chk("ovr.sticky", 64'(ovr1), 64'd1);
        mode = 2'b00;
        @(negedge clk);
        chk_zero("clear");
        mode = 2'b10;
        @(negedge clk);

        // minimum spacing 14 -> no overrun; spacing 13 -> overrun, not queued
        pulse();
        repeat (13) @(negedge clk);
        pulse();
        repeat (13) @(negedge clk);
        chk("sp14.cnt", 64'(cnt1), 64'd2);
        chk("sp14.ovr", 64'(ovr1), 64'd0);
        pulse();
        repeat (12) @(negedge clk);
        pulse();
        repeat (15) @(negedge clk);
        chk("sp13.ovr", 64'(ovr1), 64'd1);
        chk("sp13.cnt", 64'(cnt1), 64'd3);

        // diagnostic vectors
        for (int i = 0; i < 6; i++) begin
            mode = 2'b00;
            @(negedge clk);
            diag_reg = dv[i].ram;
            mode = 2'b01;
            @(negedge clk);
            chk("diag.pend", 64'(der1), 64'd0);
            chk("diag.busy", 64'(busy1), 64'd1);
            chk("diag.addr", 64'(addr1), 64'd6);
            repeat (3) @(negedge clk);
            chk("diag.er", 64'(der1), 64'(dv[i].er));
            chk("diag.data", 64'(erd1), 64'(dv[i].data));
            chk("diag.idle", 64'(busy1), 64'd0);
            diag_reg = ~diag_reg;
            repeat (4) @(negedge clk);
            chk("diag.hold_er", 64'(der1), 64'(dv[i].er));
            chk("diag.hold_data", 64'(erd1), 64'(dv[i].data));
        end

        // mode 10 -> 00 at E0+6: no publish, everything cleared
        mode = 2'b00;
        @(negedge clk);
        mode = 2'b10;
        @(negedge clk);
        #1 nv_mark = nv1;
        pulse();
        repeat (5) @(negedge clk);
        mode = 2'b00;
        @(negedge clk);
        chk_zero("abort00");
        repeat (10) @(negedge clk);
        #1 chk("abort00.pulses", 64'(nv1 - nv_mark), 64'd0);

        // reset mid-READ after one good frame
        mode = 2'b10;
        @(negedge clk);
        pulse();
        repeat (14) @(negedge clk);
        chk("pre_rst.cnt", 64'(cnt1), 64'd1);
        pulse();
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("rst_mid");
        rst = 1'b0;

        // mode 10 -> 01 mid-frame: abort, samples and count retained
        @(negedge clk);
        pulse();
        repeat (14) @(negedge clk);
        #1 nv_mark = nv1;
        pulse();
        repeat (5) @(negedge clk);
        mode = 2'b01;
        @(negedge clk);
        chk("ab01.busy", 64'(busy1), 64'd0);
        chk("ab01.addr", 64'(addr1), 64'd0);
        chk("ab01.cnt", 64'(cnt1), 64'd1);
        chk_frame1("ab01.ch");
        @(negedge clk);
        chk("ab01.diag_busy", 64'(busy1), 64'd1);
        repeat (10) @(negedge clk);
        #1 chk("ab01.pulses", 64'(nv1 - nv_mark), 64'd0);

        // 256 back-to-back frames: counter wraps 255 -> 0, no overrun
        mode = 2'b00;
        @(negedge clk);
        mode = 2'b10;
        @(negedge clk);
        #1 nv_mark = nv1;
        for (int f = 0; f < 256; f++) begin
            pulse();
            repeat (13) @(negedge clk);
            if (f == 254) chk("wrap.cnt255", 64'(cnt1), 64'd255);
        end
        chk("wrap.cnt0", 64'(cnt1), 64'd0);
        chk("wrap.ovr", 64'(ovr1), 64'd0);
        @(negedge clk);
        #1 chk("wrap.pulses", 64'(nv1 - nv_mark), 64'd256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/afe_frame_sequencer.md
# afe_frame_sequencer

Parametrised successor to the pulse-ox AFE readout buffer. On each AFE data-ready strobe it reads `NUM_CH` result registers from the AFE read-RAM port, honouring a configurable read latency. It then publishes all channels together as one packed frame with a single-cycle valid, a wrapping frame counter and a sticky overrun flag. It also runs the one-shot diagnostic read/classify used by the top-level FSM, and sits between the AFE read port and the sample FIFO/ALU path.

## Interface
Parameters:
- `NUM_CH`, 6, channels read per frame; channel k is read at RAM address k.
- `DATA_W`, 22, captured bits per channel, taken as `in_strm_data[DATA_W-1:0]`.
- `RAM_W`, 24, width of the RAM read data.
- `ADDR_W`, 3, RAM address width; requires `NUM_CH <= 2**ADDR_W`.
- `RD_LAT`, 1, cycles from `out_addr` change to valid `in_strm_data`; range 0..7.
- `DIAG_ADDR`, 6, diagnostic register address.
- `DIAG_W`, 14, diagnostic error-bit width.
- `CNT_W`, 8, frame counter width.

Ports (one clock; reset is synchronous and active-high):
- `clk`, in, 1, system clock.
- `in_reset`, in, 1, synchronous active-high reset.
- `in_data_control`, in, 2, mode: 00 idle/clear, 01 diagnostic, 10 streaming, 11 reserved (treated as 00).
- `in_strm_dn`, in, 1, AFE data-ready, level-sampled.
- `in_strm_data`, in, `RAM_W`, RAM read data.
- `out_addr`, out, `ADDR_W`, RAM read address.
- `out_samples`, out, `NUM_CH*DATA_W`, frame; channel k occupies `[k*DATA_W +: DATA_W]`.
- `out_sample_valid`, out, 1, one-cycle frame-valid pulse.
- `out_frame_cnt`, out, `CNT_W`, count of published frames.
- `out_overrun`, out, 1, sticky: strobe arrived while a frame was in progress.
- `out_busy`, out, 1, high in READ/PUBLISH/DIAG_RD.
- `out_er_data`, out, `DIAG_W`, captured diagnostic bits.
- `out_diag_er`, out, 2, 00 pending, 10 no error, 01 error.

## Operation
- States: IDLE, READ, PUBLISH, DIAG_RD, DIAG_DONE. Internal counters: `ch` and `wait`.
- Reset, mode 00 or mode 11 (any state):
  - Go to IDLE.
  - All outputs, shadow registers and counters clear to 0, including `out_frame_cnt` and `out_overrun`.
- IDLE, mode 10, `in_strm_dn`=1: go to READ with `ch`=0, `wait`=0, `out_addr`=0.
- READ, each cycle:
  - If `wait`==`RD_LAT`: capture `in_strm_data[DATA_W-1:0]` into shadow[`ch`].
    - If `ch`==`NUM_CH-1`: go to PUBLISH.
    - Otherwise: `ch`++, `out_addr`<=`ch`+1, `wait`<=0.
  - Otherwise: `wait`++.
- PUBLISH:
  - Copy shadow to `out_samples`, set `out_sample_valid`=1 for one cycle, `out_frame_cnt`++ (wraps to 0 at max).
  - Return to IDLE with `out_addr`=0.
  - `out_samples` holds its value until the next publish or clear.
- Overrun: `in_strm_dn`=1 in READ or PUBLISH sets `out_overrun`; the current frame completes unaffected and the strobe is not queued. A strobe still high in IDLE after PUBLISH starts a new frame.
- Diagnostic, mode 01 from IDLE:
  - Go to DIAG_RD with `out_addr`=`DIAG_ADDR`.
  - After `RD_LAT+1` cycles, capture `out_er_data`=`in_strm_data[DIAG_W-1:0]`.
  - Set `out_diag_er`=10 if the captured bits are zero, else 01.
  - Go to DIAG_DONE and hold until the mode leaves 01. No re-read.
- Mode changes between 01 and 10 mid-operation: abort to IDLE. No frame is published; `out_samples` is retained.

## Timing
- Let E0 be the edge at which IDLE samples the strobe.
- Channel k is captured at edge E0+(k+1)(`RD_LAT`+1).
- `out_sample_valid` is high in the cycle after edge E0+`NUM_CH`(`RD_LAT`+1)+1. With defaults that is edge E0+13.
- Each address is stable for exactly `RD_LAT`+1 cycles before its capture edge.
- Minimum strobe spacing without overrun is `NUM_CH`(`RD_LAT`+1)+2 cycles.
- Diagnostic result is valid after edge E0'+`RD_LAT`+2, where E0' is the edge that entered DIAG_RD.
- Reset overrides everything on the same edge.

## Structure
- Shared package `pulseox_pkg`:
  - mode encodings (`MODE_IDLE`, `MODE_DIAG`, `MODE_STRM`);
  - diag result codes (`DIAG_PEND`, `DIAG_OK`, `DIAG_ERR`);
  - default `DATA_W`/`RAM_W`.
- State encoding is local.
- One sub-module: `afe_rd_slot`, a latency counter that issues a capture strobe after `RD_LAT`+1 cycles. It is shared by the READ and DIAG_RD paths.

## Test plan
- Defaults; RAM model returns `0x100000+k` at address k; one strobe → valid at E0+13, channel k = `0x100000+k`, frame_cnt=1, overrun=0.
- `RD_LAT`=3, `NUM_CH`=4 → captures at E0+4,8,12,16, valid at E0+17, each address held 4 cycles.
- Second strobe at E0+5 → overrun=1 sticky, first frame correct; mode 00 clears overrun and frame_cnt.
- Mode 01, diag register `0x0000` → out_diag_er=10; rerun with `0x0040` → 01 and out_er_data=`0x0040`.
- Mode forced 10→00 at E0+6 → no valid pulse, all outputs 0; reset asserted mid-READ behaves identically.
- 256 consecutive frames with `CNT_W`=8 → frame_cnt wraps 255→0, no overrun.
